// File: rtl/mem_port_arbiter.sv
// Two-requester single-port memory arbiter with in-order read-response tracking.
// Define ARB_ROUND_ROBIN_EN to alternate contested grants; otherwise requester 0 wins.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_din,
  input  logic [DATA_W-1:0]     mem_dout
);

  logic                    last_grant_q;
  logic [READ_LATENCY-1:0] pipe_valid_q;
  logic [READ_LATENCY-1:0] pipe_id_q;
  logic                    pick1;
  logic                    issue;
  logic                    rsp_fire;

  always_comb begin
    pick1 = 1'b0;
    if (req_valid == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick1 = ~last_grant_q;
`else
      // Fixed priority; last_grant is tracked but never steers the choice.
      pick1 = last_grant_q & 1'b0;
`endif
    end else begin
      pick1 = req_valid[1];
    end
  end

  always_comb begin
    req_ready = 2'b00;
    if (!rst) begin
      req_ready = (pick1 ? 2'b10 : 2'b01) & req_valid;
    end
    issue = |req_ready;
  end

  always_comb begin
    mem_en   = issue;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (issue) begin
      mem_we   = req_we[pick1];
      mem_addr = pick1 ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
      mem_din  = pick1 ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
    end
  end

  // Stage k holds the op issued k+1 cycles ago; writes enter as bubbles.
  always_ff @(posedge clock) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      pipe_valid_q <= '0;
      pipe_id_q    <= '0;
    end else begin
      if (issue) begin
        last_grant_q <= pick1;
      end
      pipe_valid_q[0] <= issue & ~req_we[pick1];
      pipe_id_q[0]    <= pick1;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_id_q[i]    <= pipe_id_q[i-1];
      end
    end
  end

  always_comb begin
    rsp_fire  = ~rst & pipe_valid_q[READ_LATENCY-1];
    rsp_valid = 2'b00;
    rsp_rdata = '0;
    if (rsp_fire) begin
      rsp_valid = pipe_id_q[READ_LATENCY-1] ? 2'b10 : 2'b01;
      rsp_rdata = mem_dout;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a queue-based reference model.
// Follows ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_port_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic            clock = 1'b0;
  logic            rst;
  logic [1:0]      req_valid, req_ready, req_we, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, mem_din, mem_dout;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .READ_LATENCY(LAT)
  ) dut (
    .clock(clock),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  typedef struct {
    int id;
    int due;
  } pend_t;

  pend_t pend[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    model_last = 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Drive one cycle, check against the model mid-cycle, advance the model.
  task automatic step(input logic r, input logic [1:0] v, input logic [1:0] we,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic [DW-1:0] dout);
    int            gid;
    logic [1:0]    exp_rsp;
    logic [DW-1:0] exp_rd;
    rst       = r;
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    mem_dout  = dout;
    #4;
    gid = -1;
    if (!r) begin
      if (v == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
        gid = (model_last == 0) ? 1 : 0;
`else
        gid = 0;
`endif
      end else if (v[0]) gid = 0;
      else if (v[1]) gid = 1;
    end
    check_eq("req_ready", req_ready, (gid < 0) ? 2'b00 : (gid == 0 ? 2'b01 : 2'b10));
    check_eq("mem_en", mem_en, gid >= 0);
    check_eq("mem_we", mem_we, (gid >= 0) ? we[gid] : 1'b0);
    check_eq("mem_addr", mem_addr, (gid == 0) ? a0 : (gid == 1) ? a1 : '0);
    check_eq("mem_din", mem_din, (gid == 0) ? d0 : (gid == 1) ? d1 : '0);
    exp_rsp = 2'b00;
    exp_rd  = '0;
    if (r) begin
      pend.delete();
    end else if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_rsp = (pend[0].id == 0) ? 2'b01 : 2'b10;
      exp_rd  = dout;
      void'(pend.pop_front());
    end
    check_eq("rsp_valid", rsp_valid, exp_rsp);
    check_eq("rsp_rdata", rsp_rdata, exp_rd);
    if (r) begin
      model_last = 1;
    end else if (gid >= 0) begin
      model_last = gid;
      if (!we[gid]) pend.push_back('{gid, cyc + LAT});
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 2'b00, '0, '0, '0, '0, $urandom);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; mem_dout = '0;
    @(posedge clock);
    #1;
    // Reset holds everything quiet even with requests pending.
    step(1'b1, 2'b11, 2'b00, 16'h1, 16'h2, 32'h3, 32'h4, 32'h55);
    step(1'b1, 2'b01, 2'b00, 16'h1, 16'h2, 32'h3, 32'h4, 32'h66);
    // Single read, response two cycles later.
    step(1'b0, 2'b01, 2'b00, 16'h0010, 16'h0, 32'h0, 32'h0, 32'h0);
    step(1'b0, 2'b00, 2'b00, '0, '0, '0, '0, 32'h1234);
    step(1'b0, 2'b00, 2'b00, '0, '0, '0, '0, 32'hDEADBEEF);
    idle(2);
    // Four contested reads.
    for (int i = 0; i < 4; i++)
      step(1'b0, 2'b11, 2'b00, AW'(16'h100 + i), AW'(16'h200 + i), '0, '0, $urandom);
    idle(4);
    // Write from requester 1 produces no response.
    step(1'b0, 2'b10, 2'b10, 16'h0, 16'h1000, 32'h0, 32'h5, $urandom);
    idle(4);
    // Reads in flight are dropped by a one-cycle reset.
    step(1'b0, 2'b01, 2'b00, 16'h20, 16'h0, '0, '0, $urandom);
    step(1'b1, 2'b01, 2'b00, 16'h24, 16'h0, '0, '0, $urandom);
    idle(5);
    // Mixed stream R0, W1, R1.
    step(1'b0, 2'b01, 2'b00, 16'h30, 16'h0, '0, '0, $urandom);
    step(1'b0, 2'b10, 2'b10, 16'h0, 16'h34, '0, 32'h77, $urandom);
    step(1'b0, 2'b10, 2'b00, 16'h0, 16'h38, '0, '0, $urandom);
    idle(4);
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 49) == 0), 2'($urandom), 2'($urandom), AW'($urandom),
           AW'($urandom), $urandom, $urandom, $urandom);
    end
    idle(LAT + 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter READ_LATENCY, default 2, cycles from mem_en read issue to valid mem_dout; legal range 1..4.
REQ-004 SHALL use one clock and a synchronous, active-high reset; ports listed below, clock and reset first.
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req_valid  in  2  per-requester request pending (bit i = requester i).
REQ-008 req_ready  out  2  per-requester grant; request i issues when req_valid[i] && req_ready[i].
REQ-009 req_we  in  2  per-requester write (1) / read (0).
REQ-010 req_addr  in  2*ADDR_W  per-requester address; requester i at bits [i*ADDR_W +: ADDR_W].
REQ-011 req_wdata  in  2*DATA_W  per-requester write data, same packing.
REQ-012 rsp_valid  out  2  one-cycle read-response strobe for requester i.
REQ-013 rsp_rdata  out  DATA_W  read data, shared by both requesters, qualified by rsp_valid.
REQ-014 mem_en, mem_we  out  1 each  memory port enable / write enable.
REQ-015 mem_addr  out  ADDR_W; mem_din  out  DATA_W  memory port address / write data.
REQ-016 mem_dout  in  DATA_W  memory port read data.

Function
REQ-017 SHALL grant at most one requester per cycle; req_ready SHALL be combinational from req_valid and arbiter state, and SHALL never be asserted for a requester whose req_valid is 0.
REQ-018 SHALL be zero-bubble: any cycle with at least one req_valid bit set SHALL grant exactly one requester.
REQ-019 In the grant cycle, mem_en SHALL be 1 and mem_we, mem_addr, mem_din SHALL equal the granted requester's req_we, address and wdata; with no grant, mem_en = 0, mem_we = 0, and mem_addr/mem_din = 0.
REQ-020 SHALL track each issued read in a READ_LATENCY-deep shift register of {valid, requester id}; writes SHALL enter the shift register as invalid.
REQ-021 A read issued in cycle N SHALL produce rsp_valid[id] = 1 in cycle N+READ_LATENCY, with rsp_rdata = mem_dout in that cycle; writes SHALL produce no response.
REQ-022 Back-to-back reads SHALL be accepted every cycle; responses SHALL return in issue order, one per cycle, with no drops.
REQ-023 rsp_valid SHALL be one-hot or zero; rsp_rdata SHALL be 0 when rsp_valid = 0.
REQ-024 Requesters MAY deassert req_valid before being granted; a request is not issued until granted.
REQ-025 SHALL keep a 1-bit last_grant register, updated only in grant cycles.

Reset
REQ-026 While rst = 1: req_ready = 0, mem_en = 0, mem_we = 0, rsp_valid = 0, rsp_rdata = 0, shift register cleared, last_grant = 1.
REQ-027 Reads in flight when rst asserts SHALL be discarded; no rsp_valid SHALL appear for them after reset release.
REQ-028 The first cycle after rst deasserts SHALL accept grants.

Configuration
REQ-029 Macro ARB_ROUND_ROBIN_EN defined: when both req_valid bits are 1, SHALL grant the requester != last_grant; first contested grant after reset goes to requester 0.
REQ-030 Macro ARB_ROUND_ROBIN_EN undefined: requester 0 SHALL always win contention; last_grant is still maintained, but only as state.

Verification
REQ-031 Single read: req_valid=01, addr0=0x0010, mem_dout returns 0xDEADBEEF two cycles later -> req_ready=01 same cycle, mem_en=1, mem_we=0, mem_addr=0x0010; rsp_valid=01, rsp_rdata=0xDEADBEEF at N+2.
REQ-032 Contention, round robin: both valid for 4 cycles, both reads -> grants 0,1,0,1; rsp_valid=01,10,01,10 at cycles N+2..N+5.
REQ-033 Contention, macro undefined: same stimulus -> grants 0,0,0,0; req_ready[1] stays 0.
REQ-034 Write: requester 1, we=1, addr=0x1000, wdata=0x00000005 -> mem_we=1, mem_addr=0x1000, mem_din=0x5; no rsp_valid in the following 4 cycles.
REQ-035 Reset mid-flight: issue reads at N, N+1; rst=1 at N+1 for one cycle -> rsp_valid = 0 through N+5.
REQ-036 Mixed stream: R0, W1, R1 on consecutive cycles -> rsp_valid = 01, 00, 10 at N+2..N+4.
